// File: rtl/approx_max_pkg.sv
// approx_max_pkg
// Shared definitions for the approximate N-operand maximum pipeline.
//   MAX_W          widest operand the key-mask helper supports
//   TIE_LOWER_IDX  key-tie rule: the candidate from the lower lane wins
//   mask_key()     clears the low t bits of a value to form its compare key
// The candidate record (value, idx, exact-max, trunc) depends on the module
// parameters, so its packed struct is declared inside approx_max_pipe. The
// node receives the same fields as plain ports.
package approx_max_pkg;

    localparam int MAX_W = 64;

    localparam bit TIE_LOWER_IDX = 1'b1;

    // Callers zero-extend their operand to MAX_W and truncate the result back.
    function automatic logic [MAX_W-1:0] mask_key(input logic [MAX_W-1:0] value,
                                                  input int unsigned     t);
        logic [MAX_W-1:0] low_bits;
        low_bits = (MAX_W'(1) << t) - MAX_W'(1);
        return value & ~low_bits;
    endfunction

endpackage

// File: rtl/approx_max_node.sv
// approx_max_node
// Combinational two-candidate select for one tree node.
//   a_*    candidate from the lower-indexed subtree
//   b_*    candidate from the higher-indexed subtree
//   trunc  number of LSBs ignored when comparing keys (same for both sides)
//   y_*    winning value and index, plus the merged exact maximum
// The winner is chosen on masked keys. The exact maximum is merged from
// untruncated values, so the root can tell whether the approximation
// changed the answer.
module approx_max_node
    import approx_max_pkg::*;
#(
    parameter int W  = 8,
    parameter int IW = 2,
    parameter int TW = 3
) (
    input  logic [W-1:0]  a_value,
    input  logic [IW-1:0] a_idx,
    input  logic [W-1:0]  a_xmax,
    input  logic [W-1:0]  b_value,
    input  logic [IW-1:0] b_idx,
    input  logic [W-1:0]  b_xmax,
    input  logic [TW-1:0] trunc,
    output logic [W-1:0]  y_value,
    output logic [IW-1:0] y_idx,
    output logic [W-1:0]  y_xmax
);

    logic [W-1:0] key_a;
    logic [W-1:0] key_b;
    logic         take_b;

    always_comb begin
        key_a = W'(mask_key(MAX_W'(a_value), 32'(trunc)));
        key_b = W'(mask_key(MAX_W'(b_value), 32'(trunc)));
        // Side a always carries the lower lane indices, so a strict compare
        // makes a key tie resolve to the lower lane.
        if (TIE_LOWER_IDX) begin
            take_b = key_b > key_a;
        end else begin
            take_b = key_b >= key_a;
        end
        y_value = take_b ? b_value : a_value;
        y_idx   = take_b ? b_idx : a_idx;
        y_xmax  = (b_xmax > a_xmax) ? b_xmax : a_xmax;
    end

endmodule

// File: rtl/approx_max_pipe.sv
// approx_max_pipe
// Pipelined N-operand maximum with a per-vector approximation level.
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid/in_ready    operand-vector handshake (lane i at in_data[i*W +: W])
//   in_trunc             LSBs to ignore in comparisons, travels with the vector
//   out_valid/out_ready  result handshake
//   out_max, out_idx     full-precision winning value and its lane
//   out_exact            winner equals the untruncated maximum
// The nodes are stored heap-style. Node 1 is the root, node j has children
// 2j and 2j+1, and heap positions N..2N-1 are the input lanes. Every node is
// registered, so latency is log2(N) cycles. A single enable advances all
// stages together.
module approx_max_pipe
    import approx_max_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int N  = 4,
    localparam int IW = $clog2(N),
    localparam int TW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [TW-1:0]  in_trunc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_max,
    output logic [IW-1:0]  out_idx,
    output logic           out_exact
);

    typedef struct packed {
        logic [W-1:0]  value;
        logic [IW-1:0] idx;
        logic [W-1:0]  xmax;
        logic [TW-1:0] trunc;
    } cand_t;

    cand_t         leaf   [N];
    cand_t         node_d [1:N-1];
    cand_t         node_q [1:N-1];
    logic [IW:1]   valid_d;
    logic [IW:1]   valid_q;
    logic [TW-1:0] t_eff;
    logic          en;

    assign out_valid = valid_q[IW];
    assign en        = ~out_valid | out_ready;
    assign in_ready  = en;

    // Build the leaf candidates. The truncation level is clamped so that at
    // least the MSB always takes part in the comparison.
    always_comb begin
        if (int'(in_trunc) > W - 1) begin
            t_eff = TW'(W - 1);
        end else begin
            t_eff = in_trunc;
        end
        for (int i = 0; i < N; i++) begin
            leaf[i].value = in_data[i*W +: W];
            leaf[i].idx   = IW'(i);
            leaf[i].xmax  = in_data[i*W +: W];
            leaf[i].trunc = t_eff;
        end
    end

    for (genvar j = 1; j < N; j++) begin : g_node
        cand_t         lc;
        logic [W-1:0]  rc_value;
        logic [IW-1:0] rc_idx;
        logic [W-1:0]  rc_xmax;
        logic [W-1:0]  y_value;
        logic [IW-1:0] y_idx;
        logic [W-1:0]  y_xmax;

        if (2 * j >= N) begin : g_from_leaf
            assign lc       = leaf[2*j-N];
            assign rc_value = leaf[2*j+1-N].value;
            assign rc_idx   = leaf[2*j+1-N].idx;
            assign rc_xmax  = leaf[2*j+1-N].xmax;
        end else begin : g_from_node
            assign lc       = node_q[2*j];
            assign rc_value = node_q[2*j+1].value;
            assign rc_idx   = node_q[2*j+1].idx;
            assign rc_xmax  = node_q[2*j+1].xmax;
        end

        approx_max_node #(
            .W  (W),
            .IW (IW),
            .TW (TW)
        ) u_node (
            .a_value (lc.value),
            .a_idx   (lc.idx),
            .a_xmax  (lc.xmax),
            .b_value (rc_value),
            .b_idx   (rc_idx),
            .b_xmax  (rc_xmax),
            .trunc   (lc.trunc),
            .y_value (y_value),
            .y_idx   (y_idx),
            .y_xmax  (y_xmax)
        );

        // Both children belong to the same vector, so the left child's trunc
        // is the vector's trunc.
        assign node_d[j] = '{value: y_value, idx: y_idx, xmax: y_xmax, trunc: lc.trunc};
    end

    // Stage valid bits shift only on enable. Bubbles move like data and are
    // never collapsed.
    always_comb begin
        valid_d = valid_q;
        if (en) begin
            valid_d[1] = in_valid;
            for (int k = 2; k <= IW; k++) begin
                valid_d[k] = valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int j = 1; j < N; j++) begin
                node_q[j] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (en) begin
                for (int j = 1; j < N; j++) begin
                    node_q[j] <= node_d[j];
                end
            end
        end
    end

    assign out_max   = node_q[1].value;
    assign out_idx   = node_q[1].idx;
    // Gate with valid so an empty root (all zeros) does not report exact.
    assign out_exact = out_valid & (node_q[1].value == node_q[1].xmax);

endmodule

// File: tb/tb_approx_max_pipe.sv
// tb_approx_max_pipe
// Directed bench for approx_max_pipe with W=8 and N=4 (latency 2 cycles).
// Inputs change on the falling edge and outputs are sampled 1 time unit
// later. Each scenario task compares its results against hand-computed
// values.
module tb_approx_max_pipe;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic [TW-1:0]  in_trunc;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_max;
    logic [IW-1:0]  out_idx;
    logic           out_exact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    approx_max_pipe #(
        .W (W),
        .N (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_trunc  (in_trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_exact (out_exact)
    );

    // Sends one vector into an empty pipeline and waits (bounded) for its
    // result. lat counts falling edges after the accepting edge.
    task automatic drive_single(input  logic [N*W-1:0] data,
                                input  logic [TW-1:0]  trunc,
                                output logic [W-1:0]   got_max,
                                output logic [IW-1:0]  got_idx,
                                output logic           got_exact,
                                output int             lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = data;
        in_trunc  = trunc;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        #1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        got_max   = out_max;
        got_idx   = out_idx;
        got_exact = out_exact;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_trunc  = '0;
        out_ready = 1'b1;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
        end
        checks++;
        if (out_max !== 8'd0 || out_idx !== 2'd0 || out_exact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got max %0h idx %0d exact %0b expected 0/0/0",
                     out_max, out_idx, out_exact);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_exact();
        logic [W-1:0]  m;
        logic [IW-1:0] ix;
        logic          ex;
        int            lat;
        // Lanes {10,200,37,199}
        drive_single({8'd199, 8'd37, 8'd200, 8'd10}, 3'd0, m, ix, ex, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL exact_latency: got %0d expected 2", lat);
        end
        checks++;
        if (m !== 8'd200 || ix !== 2'd1 || ex !== 1'b1) begin
            errors++;
            $display("[TB] FAIL exact_result: got max %0d idx %0d exact %0b expected 200/1/1",
                     m, ix, ex);
        end
        // All lanes equal: the lowest lane wins and the result is exact
        drive_single({8'h55, 8'h55, 8'h55, 8'h55}, 3'd0, m, ix, ex, lat);
        checks++;
        if (m !== 8'h55 || ix !== 2'd0 || ex !== 1'b1) begin
            errors++;
            $display("[TB] FAIL equal_lanes: got max %0h idx %0d exact %0b expected 55/0/1",
                     m, ix, ex);
        end
    endtask

    task automatic test_approx_tie();
        logic [W-1:0]  m;
        logic [IW-1:0] ix;
        logic          ex;
        int            lat;
        // Lanes {C5,C3,10,20}, trunc 4: keys C0/C0 tie, lane 0 wins
        drive_single({8'h20, 8'h10, 8'hC3, 8'hC5}, 3'd4, m, ix, ex, lat);
        checks++;
        if (m !== 8'hC5 || ix !== 2'd0 || ex !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tie_exact: got max %0h idx %0d exact %0b expected C5/0/1",
                     m, ix, ex);
        end
        // Lanes {C3,C5,10,20}, trunc 4: lane 0 wins but true max is C5
        drive_single({8'h20, 8'h10, 8'hC5, 8'hC3}, 3'd4, m, ix, ex, lat);
        checks++;
        if (m !== 8'hC3 || ix !== 2'd0 || ex !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tie_inexact: got max %0h idx %0d exact %0b expected C3/0/0",
                     m, ix, ex);
        end
    endtask

    task automatic test_clamp();
        logic [W-1:0]  m;
        logic [IW-1:0] ix;
        logic          ex;
        int            lat;
        // Lanes {7F,80,FF,01}, trunc 7: only the MSB is compared
        drive_single({8'h01, 8'hFF, 8'h80, 8'h7F}, 3'd7, m, ix, ex, lat);
        checks++;
        if (m !== 8'h80 || ix !== 2'd1 || ex !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clamp: got max %0h idx %0d exact %0b expected 80/1/0",
                     m, ix, ex);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] vec  [6];
        logic [W-1:0]   emax [6];
        logic [IW-1:0]  eidx [6];
        logic           held_v;
        logic [W-1:0]   hmax;
        logic [IW-1:0]  hidx;
        logic           hex;
        int             sent;
        int             rcv;
        int             stray;
        vec[0] = {8'd4,  8'd3,   8'd2,   8'd1};   emax[0] = 8'd4;   eidx[0] = 2'd3;
        vec[1] = {8'd7,  8'd6,   8'd5,   8'd90};  emax[1] = 8'd90;  eidx[1] = 2'd0;
        vec[2] = {8'd7,  8'd8,   8'd250, 8'd9};   emax[2] = 8'd250; eidx[2] = 2'd1;
        vec[3] = {8'd13, 8'd130, 8'd12,  8'd11};  emax[3] = 8'd130; eidx[3] = 2'd2;
        vec[4] = {8'd64, 8'd65,  8'd66,  8'd66};  emax[4] = 8'd66;  eidx[4] = 2'd0;
        vec[5] = {8'd1,  8'd0,   8'd0,   8'd0};   emax[5] = 8'd1;   eidx[5] = 2'd3;
        sent   = 0;
        rcv    = 0;
        held_v = 1'b0;
        hmax   = '0;
        hidx   = '0;
        hex    = 1'b0;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? vec[sent] : '0;
            in_trunc  = 3'd0;
            #1;
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || out_max !== hmax || out_idx !== hidx || out_exact !== hex) begin
                    errors++;
                    $display("[TB] FAIL bp_hold: got v%0b %0d/%0d/%0b expected v1 %0d/%0d/%0b",
                             out_valid, out_max, out_idx, out_exact, hmax, hidx, hex);
                end
            end
            if (!out_ready && out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bp_in_ready_stall: got %0b expected 0", in_ready);
                end
                held_v = 1'b1;
                hmax   = out_max;
                hidx   = out_idx;
                hex    = out_exact;
            end else begin
                held_v = 1'b0;
            end
            if (out_ready) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bp_in_ready_run: got %0b expected 1", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_max !== emax[rcv] || out_idx !== eidx[rcv] || out_exact !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL bp_result%0d: got %0d/%0d/%0b expected %0d/%0d/1",
                             rcv, out_max, out_idx, out_exact, emax[rcv], eidx[rcv]);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rcv !== 6) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d expected 6", rcv);
        end
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                stray++;
            end
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL bp_no_duplicate: got %0d extra results expected 0", stray);
        end
    endtask

    task automatic test_back_to_back();
        int rcv;
        int sent;
        int first_cyc;
        int last_cyc;
        rcv       = 0;
        sent      = 0;
        first_cyc = -1;
        last_cyc  = -1;
        for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = (sent < 6);
            in_data   = {8'h01, 8'hFF, 8'h80, 8'h7F};
            in_trunc  = (sent % 2 == 0) ? 3'd0 : 3'd7;
            #1;
            if (in_valid) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_in_ready: got %0b expected 1", in_ready);
                end
            end
            if (out_valid) begin
                checks++;
                if (rcv % 2 == 0) begin
                    if (out_max !== 8'hFF || out_idx !== 2'd2 || out_exact !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL b2b_result%0d: got %0h/%0d/%0b expected FF/2/1",
                                 rcv, out_max, out_idx, out_exact);
                    end
                end else begin
                    if (out_max !== 8'h80 || out_idx !== 2'd1 || out_exact !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL b2b_result%0d: got %0h/%0d/%0b expected 80/1/0",
                                 rcv, out_max, out_idx, out_exact);
                    end
                end
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                end
                last_cyc = cyc;
                rcv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (rcv !== 6 || last_cyc - first_cyc !== 5) begin
            errors++;
            $display("[TB] FAIL b2b_throughput: got %0d results over %0d cycles expected 6 over 5",
                     rcv, last_cyc - first_cyc);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {8'd4, 8'd3, 8'd2, 8'd1};
        in_trunc  = 3'd0;
        @(negedge clk);
        in_data   = {8'd7, 8'd6, 8'd5, 8'd90};
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_max !== 8'd4) begin
            errors++;
            $display("[TB] FAIL rst_mid_inflight: got v%0b max %0d expected v1 max 4",
                     out_valid, out_max);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_max !== 8'd0 || out_idx !== 2'd0 || out_exact !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid_outputs: got v%0b %0d/%0d/%0b expected 0/0/0/0",
                     out_valid, out_max, out_idx, out_exact);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid_in_ready: got %0b expected 1", in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stray     = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                stray++;
            end
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL rst_mid_stale: got %0d results expected 0", stray);
        end
    endtask

    initial begin
        $display("[TB] starting approx_max_pipe bench");
        test_reset();
        test_exact();
        test_approx_tie();
        test_clamp();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
